// File: rtl/gemm_pkg.sv
// ---------------------------------------------------------------------------
// gemm_pkg
// Shared definitions for the GEMM result-side managers.
//   GEMM_DIM          : edge length of the square MAC array (2 for the 2x2 array)
//   gemm_out_state_t  : pass sequencing states of the output manager
// These are kept here so that larger NxN output managers can reuse them.
// ---------------------------------------------------------------------------
package gemm_pkg;

    localparam int GEMM_DIM = 2;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN0,
        DRAIN1
    } gemm_out_state_t;

endpackage

// File: rtl/gemm_output_manager_if.sv
// ---------------------------------------------------------------------------
// gemm_output_manager_if
// Row stream from the GEMM output manager to the writeback path.
//   out_row   : one row of C; lower ACC_WIDTH bits are column 0
//   out_valid : out_row holds a valid row
//   out_ready : sink accepts when out_valid & out_ready
//   out_last  : marks the final row of a pass
// Modports: master = output manager (row source), slave = writeback sink.
// ---------------------------------------------------------------------------
interface gemm_output_manager_if #(
    parameter int ACC_WIDTH = 24
);
    import gemm_pkg::*;

    logic [GEMM_DIM*ACC_WIDTH-1:0] out_row;
    logic                          out_valid;
    logic                          out_ready;
    logic                          out_last;

    modport master (
        output out_row,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_row,
        input  out_valid,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/gemm_output_manager.sv
// ---------------------------------------------------------------------------
// gemm_output_manager
// Result-side counterpart to the 2x2 GEMM input skew stage. Times one GEMM pass
// from its start pulse, captures the four MAC accumulators once the last
// skewed operand has been folded in, pulses acc_clear to the MAC array and
// then streams C out row by row over a valid/ready interface.
//
// Ports
//   clk            clock
//   reset          synchronous, active-high
//   start          pass start pulse (same cycle as the first operand enables)
//   k_len          inner-dimension length, sampled with start
//   mac11_acc..    accumulators C(0,0), C(0,1), C(1,0), C(1,1)
//   mac22_acc
//   acc_clear      one-cycle pulse telling the MACs to zero their accumulators
//   busy           high from the cycle after start until the last row is taken
//   start_dropped  one-cycle pulse: a start arrived while not idle
//   out_bus        row stream (master side): out_row/out_valid/out_ready/out_last
// ---------------------------------------------------------------------------
module gemm_output_manager
    import gemm_pkg::*;
#(
    parameter int ACC_WIDTH   = 24,
    parameter int K_WIDTH     = 8,
    parameter int MAC_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [K_WIDTH-1:0]   k_len,
    input  logic [ACC_WIDTH-1:0] mac11_acc,
    input  logic [ACC_WIDTH-1:0] mac12_acc,
    input  logic [ACC_WIDTH-1:0] mac21_acc,
    input  logic [ACC_WIDTH-1:0] mac22_acc,
    output logic                 acc_clear,
    output logic                 busy,
    output logic                 start_dropped,
    gemm_output_manager_if.master out_bus
);

    // Two spare bits over k_len so k_len + 1 + MAC_LATENCY never wraps
    // for MAC_LATENCY up to 2.
    localparam int CNT_WIDTH = K_WIDTH + 2;

    gemm_out_state_t        state;
    logic [CNT_WIDTH-1:0]   count;
    logic [CNT_WIDTH-1:0]   count_load;
    logic [ACC_WIDTH-1:0]   cap00;
    logic [ACC_WIDTH-1:0]   cap01;
    logic [ACC_WIDTH-1:0]   cap10;
    logic [ACC_WIDTH-1:0]   cap11;
    logic                   out_valid_q;
    logic                   handshake;

    // The counter is loaded so that it reads 1 in cycle k_len+1+MAC_LATENCY,
    // i.e. the first cycle in which the last MAC (mac22) holds its final sum.
    // Loading it from k_len is the only place k_len is needed, so the counter
    // itself is the latched copy of k_len.
    assign count_load = CNT_WIDTH'(k_len) + CNT_WIDTH'(MAC_LATENCY + 1);

    assign handshake = out_valid_q & out_bus.out_ready;

    // Pass sequencer. acc_clear and start_dropped are single-cycle pulses, so
    // they default low every cycle and are only raised on the relevant edge.
    // out_valid is raised on entry to DRAIN0 and only lowered after the row-1
    // handshake, so it never depends combinationally on out_ready.
    // The k_len==0 shortcut goes straight to DRAIN0 with zeroed results and
    // without a clear, because the MACs never accumulated anything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            count         <= '0;
            cap00         <= '0;
            cap01         <= '0;
            cap10         <= '0;
            cap11         <= '0;
            acc_clear     <= 1'b0;
            busy          <= 1'b0;
            start_dropped <= 1'b0;
            out_valid_q   <= 1'b0;
        end else begin
            acc_clear     <= 1'b0;
            start_dropped <= start && (state != IDLE);

            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (k_len == '0) begin
                            cap00       <= '0;
                            cap01       <= '0;
                            cap10       <= '0;
                            cap11       <= '0;
                            out_valid_q <= 1'b1;
                            state       <= DRAIN0;
                        end else begin
                            count <= count_load;
                            state <= ACCUM;
                        end
                    end
                end

                ACCUM: begin
                    if (count == CNT_WIDTH'(1)) begin
                        cap00       <= mac11_acc;
                        cap01       <= mac12_acc;
                        cap10       <= mac21_acc;
                        cap11       <= mac22_acc;
                        acc_clear   <= 1'b1;
                        out_valid_q <= 1'b1;
                        count       <= '0;
                        state       <= DRAIN0;
                    end else begin
                        count <= count - CNT_WIDTH'(1);
                    end
                end

                DRAIN0: begin
                    if (handshake) begin
                        state <= DRAIN1;
                    end
                end

                DRAIN1: begin
                    if (handshake) begin
                        out_valid_q <= 1'b0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Row mux: the capture registers only change on entry to DRAIN0, so the
    // selected row stays stable for as long as the sink stalls.
    always_comb begin
        out_bus.out_row  = '0;
        out_bus.out_last = 1'b0;
        case (state)
            DRAIN0: begin
                out_bus.out_row = {cap01, cap00};
            end
            DRAIN1: begin
                out_bus.out_row  = {cap11, cap10};
                out_bus.out_last = 1'b1;
            end
            default: begin
                out_bus.out_row  = '0;
                out_bus.out_last = 1'b0;
            end
        endcase
    end

    assign out_bus.out_valid = out_valid_q;

endmodule
